// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 16-bit pipelined core, between EX/MEM and MEM/WB.
//
// Non-memory instructions pass through to write-back in one cycle. Loads and stores
// issue a registered req/ack access to data memory and stall upstream until the
// access completes, then write back the load data (or the store address for stores).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid .. ex_wr_reg      instruction from EX (ALU result, store data, control)
//   stall                      EX inputs held, not consumed this cycle
//   mem_req/we/addr/wdata      registered request to data memory
//   mem_rdata, mem_ack         memory response
//   wb_valid/data/reg_wr/wr_reg MEM/WB register, valid for one cycle per instruction
//   mem_err                    sticky access-timeout flag
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT cycles
// without mem_ack. Without it the stage waits indefinitely and mem_err is tied 0.

module mem_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_dst,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              ex_reg_wr,
    input  logic [REG_W-1:0]  ex_wr_reg,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_wr,
    output logic [REG_W-1:0]  wb_wr_reg,
    output logic              mem_err
);

    typedef enum logic {StIdle, StAccess} state_t;

    state_t             state;
    logic               lat_reg_wr;
    logic [REG_W-1:0]   lat_wr_reg;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CntW-1:0] wait_cnt;
`else
    assign mem_err = 1'b0;
`endif

    // Purely state-derived: no combinational path from ex_* or mem_ack.
    assign stall = (state == StAccess);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_reg_wr  <= 1'b0;
            wb_wr_reg  <= '0;
            lat_reg_wr <= 1'b0;
            lat_wr_reg <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
`endif
        end else begin
            // MEM/WB slot is a one-cycle pulse unless refilled below.
            wb_valid  <= 1'b0;
            wb_reg_wr <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (ex_valid) begin
                        if (ex_mem_rd || ex_mem_wr) begin
                            mem_req    <= 1'b1;
                            mem_we     <= ex_mem_wr;  // rd+wr together acts as a store
                            mem_addr   <= ex_dst;
                            mem_wdata  <= ex_st_data;
                            lat_reg_wr <= ex_reg_wr;
                            lat_wr_reg <= ex_wr_reg;
                            state      <= StAccess;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt   <= '0;
`endif
                        end else begin
                            wb_valid  <= 1'b1;
                            wb_data   <= ex_dst;
                            wb_reg_wr <= ex_reg_wr;
                            wb_wr_reg <= ex_wr_reg;
                        end
                    end
                end
                StAccess: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        state     <= StIdle;
                        wb_valid  <= 1'b1;
                        wb_data   <= mem_we ? mem_addr : mem_rdata;
                        wb_reg_wr <= mem_we ? 1'b0 : lat_reg_wr;
                        wb_wr_reg <= lat_wr_reg;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CntW'(TIMEOUT - 1)) begin
                        mem_req   <= 1'b0;
                        state     <= StIdle;
                        wb_valid  <= 1'b1;
                        wb_data   <= mem_addr;
                        wb_reg_wr <= 1'b0;
                        wb_wr_reg <= lat_wr_reg;
                        mem_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CntW'(1);
                    end
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [15:0] ex_dst;
    logic [15:0] ex_st_data;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_reg_wr;
    logic [3:0]  ex_wr_reg;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_reg_wr;
    logic [3:0]  wb_wr_reg;
    logic        mem_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        reg_wr;
        logic [3:0]  wr_reg;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   wb_cyc[$];

    mem_stage #(
        .DATA_W (16),
        .REG_W  (4),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_dst    (ex_dst),
        .ex_st_data(ex_st_data),
        .ex_mem_rd (ex_mem_rd),
        .ex_mem_wr (ex_mem_wr),
        .ex_reg_wr (ex_reg_wr),
        .ex_wr_reg (ex_wr_reg),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_reg_wr (wb_reg_wr),
        .wb_wr_reg (wb_wr_reg),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write-back must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) check("wb_data", 32'(wb_data), 32'(e.data));
                check("wb_reg_wr", 32'(wb_reg_wr), 32'(e.reg_wr));
                if (e.reg_wr) check("wb_wr_reg", 32'(wb_wr_reg), 32'(e.wr_reg));
                wb_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] dst, input logic [15:0] sd, input logic rd,
                         input logic wr, input logic rw, input logic [3:0] rg);
        ex_valid   = 1'b1;
        ex_dst     = dst;
        ex_st_data = sd;
        ex_mem_rd  = rd;
        ex_mem_wr  = wr;
        ex_reg_wr  = rw;
        ex_wr_reg  = rg;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
    endtask

    // Waits through ACCESS, checking the held request, and acks in cycle ack_at.
    task automatic access(input string tag, input logic [15:0] addr, input logic we,
                          input logic [15:0] wdata, input logic [15:0] rdata, input int ack_at);
        for (int i = 1; i <= ack_at; i++) begin
            @(negedge clk);
            check({tag, "_req"}, 32'(mem_req), 32'(1));
            check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
            check({tag, "_we"}, 32'(mem_we), 32'(we));
            if (we) check({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
            check({tag, "_stall"}, 32'(stall), 32'(1));
            mem_ack   = (i == ack_at);
            mem_rdata = rdata;
            tick();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_ex();
        ex_dst = '0; ex_st_data = '0; ex_reg_wr = 1'b0; ex_wr_reg = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Reset
        repeat (3) tick();
        check("rst_req", 32'(mem_req), 32'(0));
        check("rst_wb_valid", 32'(wb_valid), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_stall", 32'(stall), 32'(0));
        check("post_rst_req", 32'(mem_req), 32'(0));
        check("post_rst_err", 32'(mem_err), 32'(0));
        check("post_rst_wb_data", 32'(wb_data), 32'(0));
        tick();

        // ALU pass-through
        drive(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 4'd5);
        sb.push_back('{data: 16'h1234, reg_wr: 1'b1, wr_reg: 4'd5, chk_data: 1'b1});
        tick();
        idle_ex();
        @(negedge clk);
        check("alu_req", 32'(mem_req), 32'(0));
        check("alu_wb_valid", 32'(wb_valid), 32'(1));
        tick();

        // Back-to-back ALU ops, second with reg_wr = 0
        drive(16'h00AA, 16'h0, 1'b0, 1'b0, 1'b1, 4'd1);
        sb.push_back('{data: 16'h00AA, reg_wr: 1'b1, wr_reg: 4'd1, chk_data: 1'b1});
        tick();
        drive(16'h5500, 16'h0, 1'b0, 1'b0, 1'b0, 4'd2);
        sb.push_back('{data: 16'h5500, reg_wr: 1'b0, wr_reg: 4'd2, chk_data: 1'b1});
        tick();
        idle_ex();
        tick();

        // Load 0x0040, ack in the third ACCESS cycle
        drive(16'h0040, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'd3);
        sb.push_back('{data: 16'hBEEF, reg_wr: 1'b1, wr_reg: 4'd3, chk_data: 1'b1});
        tick();
        idle_ex();
        access("ld", 16'h0040, 1'b0, 16'h0, 16'hBEEF, 3);
        @(negedge clk);
        check("ld_stall_after", 32'(stall), 32'(0));
        check("ld_req_after", 32'(mem_req), 32'(0));
        tick();

        // Store 0xA5A5 to 0x0100, ack in the first ACCESS cycle
        drive(16'h0100, 16'hA5A5, 1'b0, 1'b1, 1'b1, 4'd2);
        sb.push_back('{data: 16'h0100, reg_wr: 1'b0, wr_reg: 4'd2, chk_data: 1'b1});
        tick();
        idle_ex();
        access("st", 16'h0100, 1'b1, 16'hA5A5, 16'h0, 1);
        tick();

        // rd and wr together behave as a store
        drive(16'h0200, 16'h1111, 1'b1, 1'b1, 1'b1, 4'd4);
        sb.push_back('{data: 16'h0200, reg_wr: 1'b0, wr_reg: 4'd4, chk_data: 1'b1});
        tick();
        idle_ex();
        access("rdwr", 16'h0200, 1'b1, 16'h1111, 16'h9999, 2);
        tick();

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_wb", 32'(wb_valid), 32'(0));
        check("idle_ack_stall", 32'(stall), 32'(0));
        tick();

        // Load immediately followed by ALU op held during the stall
        drive(16'h0044, 16'h0, 1'b1, 1'b0, 1'b1, 4'd7);
        sb.push_back('{data: 16'h1357, reg_wr: 1'b1, wr_reg: 4'd7, chk_data: 1'b1});
        tick();
        drive(16'h0007, 16'h0, 1'b0, 1'b0, 1'b1, 4'd6);
        sb.push_back('{data: 16'h0007, reg_wr: 1'b1, wr_reg: 4'd6, chk_data: 1'b1});
        access("ld_hold", 16'h0044, 1'b0, 16'h0, 16'h1357, 2);
        tick();  // held ALU op consumed in the first IDLE cycle
        idle_ex();
        repeat (2) tick();
        check("hold_sb_empty", 32'(sb.size()), 32'(0));
        if (wb_cyc.size() >= 2)
            check("hold_wb_gap", 32'(wb_cyc[wb_cyc.size()-1] - wb_cyc[wb_cyc.size()-2]), 32'(1));
        else
            check("hold_wb_count", 32'(wb_cyc.size()), 32'(2));

        // Reset in the middle of an access
        drive(16'h0080, 16'h0, 1'b1, 1'b0, 1'b1, 4'd8);
        tick();
        idle_ex();
        @(negedge clk);
        check("mid_stall_before", 32'(stall), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'(0));
        check("mid_rst_stall", 32'(stall), 32'(0));
        sb.delete();
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            check("late_ack_wb", 32'(wb_valid), 32'(0));
            check("late_ack_req", 32'(mem_req), 32'(0));
        end
        mem_ack = 1'b0;
        tick();

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 4 ACCESS cycles
        drive(16'h0300, 16'h0, 1'b1, 1'b0, 1'b1, 4'd9);
        sb.push_back('{data: 16'h0, reg_wr: 1'b0, wr_reg: 4'd9, chk_data: 1'b0});
        tick();
        idle_ex();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("to_req", 32'(mem_req), 32'(1));
            check("to_err_pending", 32'(mem_err), 32'(0));
            tick();
        end
        @(negedge clk);
        check("to_req_drop", 32'(mem_req), 32'(0));
        check("to_err", 32'(mem_err), 32'(1));
        check("to_stall", 32'(stall), 32'(0));
        repeat (2) tick();
        check("to_err_sticky", 32'(mem_err), 32'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Ack on the 4th cycle wins over the timeout
        drive(16'h0304, 16'h0, 1'b1, 1'b0, 1'b1, 4'd10);
        sb.push_back('{data: 16'h4242, reg_wr: 1'b1, wr_reg: 4'd10, chk_data: 1'b1});
        tick();
        idle_ex();
        access("to_ack", 16'h0304, 1'b0, 16'h0, 16'h4242, 4);
        @(negedge clk);
        check("to_ack_err", 32'(mem_err), 32'(0));
        tick();
`endif

        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
